// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared defaults and helpers for the multi-channel clock divider
package clkdiv_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int unsigned DEFAULT_DIV_DEF = 32'd7399999;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one 50% divider channel with a one-entry pending divisor
//   clk, rst_n     : clock, asynchronous active-low reset
//   en_i, sync_i   : run enable, realign pulse
//   acc_i          : config accepted for this channel (div_i, phase_i)
//   pend_o         : a divisor is waiting to be applied
//   clk_o, tick_o  : divided clock and one-cycle toggle strobe
//   CLKDIV_PHASE_EN: adds a phase preload loaded into the counter on sync
module clkdiv_channel import clkdiv_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             acc_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] phase_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pv_q, pv_d, pv_e, div_s, sync_cnt;
  logic pend_q, pend_d, pend_e, clk_q, clk_d, tick_q, tick_d, tc;
  // divisor in force right after a sync: a stored pending value wins
  assign div_s = pend_q ? pv_q : div_q;
`ifdef CLKDIV_PHASE_EN
  logic [CNT_W-1:0] phase_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase_q <= '0;
    else if (acc_i) phase_q <= phase_i;
  assign sync_cnt = (phase_q < div_s) ? phase_q : div_s;
`else
  logic unused_phase;
  assign unused_phase = ^phase_i;
  assign sync_cnt = '0;
`endif
  always_comb begin
    // an accept on the terminal-count edge takes effect on that same edge
    pend_e = pend_q | acc_i;
    pv_e = acc_i ? div_i : pv_q;
    tc = cnt_q == div_q;
    cnt_d = cnt_q;
    div_d = div_q;
    pv_d = pv_e;
    pend_d = pend_e;
    clk_d = clk_q;
    tick_d = 1'b0;
    if (sync_i) begin
      cnt_d = sync_cnt;
      clk_d = 1'b0;
      div_d = div_s;
      pend_d = acc_i;
    end else if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
      clk_d = clk_q ^ tc;
      tick_d = tc;
      div_d = (tc && pend_e) ? pv_e : div_q;
      pend_d = pend_e & ~tc;
    end else if (pend_q) begin
      div_d = pv_q;
      cnt_d = '0;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= DIV_RST;
      pv_q <= '0;
      pend_q <= 1'b0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      pv_q <= pv_d;
      pend_q <= pend_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  assign pend_o = pend_q;
  assign clk_o = clk_q;
  assign tick_o = tick_q;
endmodule

// File: rtl/clock_divider_mc.sv
// clock_divider_mc: NUM_CH programmable 50% clock dividers with tick strobes
//   clk_74, reset_n      : system clock, asynchronous active-low reset
//   ch_en                : per-channel run enable
//   sync                 : restart all channels together
//   cfg_valid/cfg_ready  : divisor config handshake, target cfg_ch
//   cfg_div, cfg_phase   : new divisor (half-period N+1), phase preload
//   clk_out, tick        : divided clocks and toggle strobes
//   CLKDIV_PHASE_EN      : enables cfg_phase preload on sync
module clock_divider_mc import clkdiv_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk_74,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic [NUM_CH-1:0] pend;
  logic [2**CH_W-1:0] busy;
  // unused channel codes never read busy, so out-of-range requests are accepted and dropped
  always_comb begin
    busy = '0;
    busy[NUM_CH-1:0] = pend;
  end
  assign cfg_ready = reset_n & ~busy[cfg_ch];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(.CNT_W(CNT_W), .DIV_RST(CNT_W'(DEFAULT_DIV))) u_ch (
      .clk(clk_74),
      .rst_n(reset_n),
      .en_i(ch_en[i]),
      .sync_i(sync),
      .acc_i(cfg_valid & cfg_ready & (cfg_ch == CH_W'(i))),
      .div_i(cfg_div),
      .phase_i(cfg_phase),
      .pend_o(pend[i]),
      .clk_o(clk_out[i]),
      .tick_o(tick[i])
    );
  end
endmodule

// File: tb/tb_clock_divider_mc.sv
// tb_clock_divider_mc: randomized check of clock_divider_mc against a countdown model
module tb_clock_divider_mc;
  localparam int NCH = 4;
  localparam int DW = 8;
  localparam int DDIV = 4;
  logic clk_74 = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic sync = 1'b0;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [DW-1:0] cfg_phase = '0;
  logic cfg_ready;
  logic [NCH-1:0] clk_out, tick;
  int n_chk = 0;
  int n_err = 0;
  // model: cycles left until the next toggle edge, per channel
  int m_div[NCH], m_left[NCH], m_pv[NCH], m_pp[NCH], m_ph[NCH];
  bit m_has[NCH];
  logic [NCH-1:0] m_clk, m_tick;

  always #5 clk_74 = ~clk_74;

  clock_divider_mc #(.NUM_CH(NCH), .CNT_W(DW), .DEFAULT_DIV(DDIV)) dut (
    .clk_74(clk_74), .reset_n(reset_n), .ch_en(ch_en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .clk_out(clk_out), .tick(tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = DDIV;
      m_left[i] = DDIV + 1;
      m_has[i] = 0;
      m_pv[i] = 0;
      m_pp[i] = 0;
      m_ph[i] = 0;
    end
    m_clk = '0;
    m_tick = '0;
  endtask

  task automatic store(input int i);
    m_has[i] = 1;
    m_pv[i] = int'(cfg_div);
    m_pp[i] = int'(cfg_phase);
`ifdef CLKDIV_PHASE_EN
    m_ph[i] = m_pp[i];
`endif
  endtask

  task automatic apply(input int i);
    m_div[i] = m_pv[i];
    m_has[i] = 0;
  endtask

  task automatic step();
    bit acc;
    acc = cfg_valid && !m_has[cfg_ch];
    for (int i = 0; i < NCH; i++) begin
      bit a;
      a = acc && (int'(cfg_ch) == i);
      if (sync) begin
        if (m_has[i]) apply(i);
        m_left[i] = m_div[i] - ((m_ph[i] < m_div[i]) ? m_ph[i] : m_div[i]) + 1;
        m_clk[i] = 1'b0;
        m_tick[i] = 1'b0;
        if (a) store(i);
      end else if (ch_en[i]) begin
        if (a) store(i);
        m_left[i]--;
        m_tick[i] = (m_left[i] == 0);
        if (m_left[i] == 0) begin
          m_clk[i] = ~m_clk[i];
          if (m_has[i]) apply(i);
          m_left[i] = m_div[i] + 1;
        end
      end else begin
        m_tick[i] = 1'b0;
        if (m_has[i]) begin
          apply(i);
          m_left[i] = m_div[i] + 1;
        end
        if (a) store(i);
      end
    end
  endtask

  // entered and left on a falling edge
  task automatic cycle(input logic [NCH-1:0] en, input logic s, input logic v,
                       input logic [1:0] ch, input logic [DW-1:0] dv, input logic [DW-1:0] ph);
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("tick", 32'(tick), 32'(m_tick));
    ch_en = en;
    sync = s;
    cfg_valid = v;
    cfg_ch = ch;
    cfg_div = dv;
    cfg_phase = ph;
    #1 chk("cfg_ready", 32'(cfg_ready), 32'(!m_has[ch]));
    @(posedge clk_74);
    step();
    @(negedge clk_74);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_74);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    ch_en = '1;
    reset_n = 1'b1;
    repeat (7) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    cycle(4'hf, 0, 1, 2'd0, 8'd1, 8'd0);
    cycle(4'hf, 0, 1, 2'd0, 8'd3, 8'd0);
    cycle(4'hf, 0, 1, 2'd1, 8'd2, 8'd0);
    cycle(4'hf, 0, 1, 2'd2, 8'd0, 8'd0);
    repeat (20) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    cycle(4'hf, 0, 1, 2'd3, 8'd4, 8'd2);
    repeat (7) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    cycle(4'hf, 1, 0, 2'd0, 8'd0, 8'd0);
    repeat (12) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    cycle(4'b0111, 0, 1, 2'd3, 8'd5, 8'd0);
    repeat (4) cycle(4'b0111, 0, 0, 2'd3, 8'd0, 8'd0);
    repeat (8) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    cycle(4'hf, 0, 1, 2'd0, 8'd6, 8'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clk_out", 32'(clk_out), 32'd0);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    repeat (2) @(negedge clk_74);
    reset_n = 1'b1;
    repeat (12) cycle(4'hf, 0, 0, 2'd0, 8'd0, 8'd0);
    for (int k = 0; k < 3000; k++) begin
      logic s, v;
      s = ($urandom % 40) == 0;
      v = !s && (($urandom % 4) == 0);
      cycle((($urandom % 8) == 0) ? 4'($urandom) : 4'hf, s, v, 2'($urandom),
            8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
